// File: rtl/uart_ctrl_if.sv
// MEM-stage data bus seen by the UART controller: strobes, address, store data
// and the combinational read-data return path.
interface uart_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped UART (TXD/RXD/CON) on the MEM-stage bus: 8N1 transmitter with a
// one-byte holding register, mid-bit sampling receiver, and a level interrupt.
module uart_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE         = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   TXD_ADDR  = BASE;
  localparam logic [31:0]   RXD_ADDR  = BASE + 32'd4;
  localparam logic [31:0]   CON_ADDR  = BASE + 32'd8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic txd_wr, con_wr, rxd_rd, con_rd;
  logic tx_irq_en, rx_irq_en, tx_done, rx_valid, rx_overrun, tx_busy;
  logic [7:0] thr, rx_data;
  logic       thr_full;
  logic       unused_wdata;

  state_t        tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_out_n, tx_load, tx_done_set;

  state_t        rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic [1:0]    rx_sync;
  logic          rx_s, rx_load;

  assign txd_wr       = bus.wr && (bus.addr == TXD_ADDR);
  assign con_wr       = bus.wr && (bus.addr == CON_ADDR);
  assign rxd_rd       = bus.rd && (bus.addr == RXD_ADDR);
  assign con_rd       = bus.rd && (bus.addr == CON_ADDR);
  assign tx_busy      = thr_full || (tx_state != IDLE);
  assign rx_s         = rx_sync[1];
  assign unused_wdata = ^bus.wdata[31:8];

  always_comb begin
    bus.rdata = '0;
    if (rxd_rd)
      bus.rdata = {24'b0, rx_data};
    else if (con_rd)
      bus.rdata = {26'b0, rx_overrun, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
  end

  // The serial output is registered, so the next line level is decided alongside the next state.
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt + CW'(1);
    tx_bit_n    = tx_bit;
    tx_shift_n  = tx_shift;
    tx_out_n    = 1'b1;
    tx_load     = 1'b0;
    tx_done_set = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        if (thr_full) begin
          tx_load    = 1'b1;
          tx_shift_n = thr;
          tx_state_n = START;
          tx_out_n   = 1'b0;
        end
      end
      START: begin
        tx_out_n = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = DATA;
          tx_out_n   = tx_shift[0];
        end
      end
      DATA: begin
        tx_out_n = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            tx_out_n   = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_out_n   = tx_shift[1];
          end
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n    = '0;
          tx_done_set = 1'b1;
          if (thr_full) begin
            tx_load    = 1'b1;
            tx_shift_n = thr;
            tx_state_n = START;
            tx_out_n   = 1'b0;
          end else begin
            tx_state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    unique case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        if (!rx_s) rx_state_n = START;
      end
      START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = STOP;
        end
      end
      STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = IDLE;
          rx_load    = rx_s;
        end
      end
    endcase
  end

  // A write landing on the same edge the shifter takes THR is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
      thr      <= '0;
      thr_full <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_out_n;
      if (txd_wr && (!thr_full || tx_load)) begin
        thr      <= bus.wdata[7:0];
        thr_full <= 1'b1;
      end else if (tx_load) begin
        thr      <= '0;
        thr_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (rx_load) rx_data <= rx_shift;
    end
  end

  // Flag sets take priority over the read-side clears on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_irq_en  <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_done    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (con_wr) {rx_irq_en, tx_irq_en} <= bus.wdata[1:0];
      if (tx_done_set)  tx_done <= 1'b1;
      else if (con_rd)  tx_done <= 1'b0;
      if (rx_load)      rx_valid <= 1'b1;
      else if (rxd_rd)  rx_valid <= 1'b0;
      if (rx_load && rx_valid && !rxd_rd) rx_overrun <= 1'b1;
      else if (con_rd)                    rx_overrun <= 1'b0;
      irq <= (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);
    end
  end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped UART controller on the MEM-stage data bus. It sits alongside the data memory, directly downstream of the EX/MEM pipeline register. It takes the registered ALU result as the address, the store data, and the read/write strobes from the MEM stage. It returns read data to the MEM/WB register, drives the serial pins, and raises an interrupt request toward the control unit.

## Interface
Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); minimum 4.
- BASE, 32'h40000018, byte address of TXD. RXD is at BASE+4 and CON is at BASE+8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, sampled on the rising edge of clk.
- rd  input  1  MEM-stage read strobe.
- wr  input  1  MEM-stage write strobe.
- addr  input  32  MEM-stage byte address (the ALU result).
- wdata  input  32  store data; only bits [7:0] or [1:0] are used.
- rdata  output  32  combinational read data.
- uart_rx  input  1  asynchronous serial input; idles high.
- uart_tx  output  1  serial output; registered.
- irq  output  1  level interrupt request; registered.

## Operation
- Decode uses exact 32-bit equality on addr. Unmapped addresses read as 0 and writes to them are ignored.
- TXD write (wr, addr==BASE):
  - If the holding register (THR) is empty, store wdata[7:0] in THR and mark it full.
  - If THR is full, the write is dropped silently.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with THR full: move THR into the shifter, clear THR, enter START.
  - Each state lasts CLKS_PER_BIT cycles. DATA sends 8 bits, LSB first.
  - At the end of STOP, set tx_done. If THR is full, go directly to START with the next byte; otherwise go to IDLE.
  - uart_tx is 1 in IDLE and STOP, 0 in START, and the data bit in DATA.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a synchronized low enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat it as a false start and return to IDLE; if low, proceed.
  - DATA: 8 samples, each CLKS_PER_BIT apart, mid-bit, LSB first.
  - STOP: sample the stop bit. If 1, load rx_data and set rx_valid; if rx_valid was already 1, also set rx_overrun. If 0, it is a framing error: discard the byte and leave the flags unchanged. Return to IDLE after the sample.
- RXD read: rdata = {24'b0, rx_data}. The edge that ends the read cycle clears rx_valid.
- CON register layout: bit0 tx_irq_en (RW), bit1 rx_irq_en (RW), bit2 tx_done, bit3 rx_valid, bit4 tx_busy (THR full or TX FSM not IDLE), bit5 rx_overrun. All other bits read 0.
  - A write updates bits [1:0] only.
  - A read clears tx_done and rx_overrun at the ending edge.
- irq is registered: irq <= (tx_irq_en & tx_done) | (rx_irq_en & rx_valid).

## Timing
- Reset values:
  - uart_tx=1, irq=0.
  - All flags, enables, THR, rx_data, and the shifters are 0.
  - Both FSMs are IDLE; synchronizer flops are 1.
  - rdata=0 whenever rd=0.
- Reset mid-frame aborts the frame. uart_tx is 1 from the reset edge onward and the partially received byte is lost.
- rdata is valid in the same cycle as rd. Reads have no side effect other than the clears listed above.
- TXD write sampled at edge k:
  - THR is full after edge k.
  - uart_tx falls after edge k+1.
  - tx_done is set at edge k+1+10·CLKS_PER_BIT.
  - irq rises one edge later if enabled.
- Back-to-back frames have no idle gap: the stop bit is exactly CLKS_PER_BIT cycles, then START begins.
- RX latency: rx_valid is set 2 synchronizer cycles plus about 9.5·CLKS_PER_BIT after the falling edge of the start bit.
- Simultaneous events:
  - Flag set and read-clear on the same edge: set wins.
  - RXD read and a new byte on the same edge: new byte loaded, rx_valid stays 1, no overrun.
  - TXD write on the edge THR empties into the shifter: the write is accepted and THR is full afterwards.
- rd and wr both asserted: both are handled independently.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold reset for 2 cycles, then check uart_tx=1, irq=0, CON read=0, RXD read=0.
- TX single byte: write 0x1A5 to BASE. Required: uart_tx stream 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each for 4 cycles; CON bit2=1 after 40 cycles; a CON read then returns bit2=0.
- TX buffering: write 0x11, then 0x22, then 0x33 back-to-back. Required: 0x11 and 0x22 sent with no gap; 0x33 dropped; CON bit4=1 throughout, and 0 one cycle after the second stop bit.
- RX with irq: write CON=2, then drive frame 0x3C on uart_rx. Required: irq=1 and RXD=0x3C. After the RXD read, irq=0 within 2 cycles.
- RX overrun and framing: send 0x01 then 0x02 without reading. Required: RXD=0x02 and CON bit5=1. Then send 0x7F with stop=0: required RXD still 0x02.
- False start and reset: a 1-cycle low glitch on uart_rx sets no flags. Assert reset mid-TX-frame: uart_tx=1 the next cycle and CON=0.
